// File: rtl/hex_pkg.sv
// Shared constants and FSM state type for the ASCII-hex parser.
// Character codes for separators are kept here so sub-blocks agree.
package hex_pkg;

  localparam logic [7:0] CHAR_SP    = 8'h20;
  localparam logic [7:0] CHAR_COMMA = 8'h2C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/ascii_hex_digit.sv
// Classifies one ASCII byte as hex digit, word terminator or invalid.
// Purely combinational; nibble is zero when the byte is not a digit.
module ascii_hex_digit
  import hex_pkg::*;
(
  input  logic [7:0] i_ascii,
  output logic       o_is_digit,
  output logic       o_is_term,
  output logic [3:0] o_nibble
);

  logic w_dec;
  logic w_upper;
  logic w_lower;

  assign w_dec   = (i_ascii >= 8'h30) && (i_ascii <= 8'h39);
  assign w_upper = (i_ascii >= 8'h41) && (i_ascii <= 8'h46);
  assign w_lower = (i_ascii >= 8'h61) && (i_ascii <= 8'h66);

  // Decode the character class and its nibble value
  always_comb begin
    o_is_digit = 1'b0;
    o_is_term  = 1'b0;
    o_nibble   = 4'h0;
    unique case (1'b1)
      w_dec: begin
        o_is_digit = 1'b1;
        o_nibble   = i_ascii[3:0];
      end
      w_upper, w_lower: begin
        o_is_digit = 1'b1;
        o_nibble   = i_ascii[3:0] + 4'd9;
      end
      (i_ascii == CHAR_SP),
      (i_ascii == CHAR_COMMA),
      (i_ascii == CHAR_CR),
      (i_ascii == CHAR_LF): begin
        o_is_term = 1'b1;
      end
      default: begin
        o_is_digit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hex_to_bits.sv
// Parses a stream of ASCII hex characters into an N_BITS word.
// Words end at a separator and leave on a registered valid/ready port.
module hex_to_bits
  import hex_pkg::*;
#(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_BITS-1:0] m_bits,
  output logic              m_err
);

  localparam int N_NIBBLES = (N_BITS + 3) / 4;
  localparam int W         = 4 * N_NIBBLES;
  localparam logic [W-1:0] LO_MASK =
    {W{1'b1}} >> (W - N_BITS);

  state_t            r_state;
  logic [W-1:0]      r_acc;
  logic              r_err;
  logic              r_m_valid;
  logic [N_BITS-1:0] r_m_bits;
  logic              r_m_err;

  logic              w_is_digit;
  logic              w_is_term;
  logic [3:0]        w_nibble;
  logic              w_take;
  logic [W-1:0]      w_next;
  logic              w_drop;
  logic              w_ovf;

  ascii_hex_digit u_dig (
    .i_ascii    (s_data),
    .o_is_digit (w_is_digit),
    .o_is_term  (w_is_term),
    .o_nibble   (w_nibble)
  );

  assign s_ready = reset && (r_state != EMIT);
  assign w_take  = s_valid && s_ready;

  // Next accumulator value and overflow detection for a digit
  always_comb begin
    w_next = W'(w_nibble);
    w_drop = 1'b0;
    if (r_state == ACCUM) begin
      w_next = (r_acc << 4) | W'(w_nibble);
      w_drop = |r_acc[W-1 -: 4];
    end
    w_ovf = w_drop || (|(w_next & ~LO_MASK));
  end

  // Parser FSM with accumulator and registered output
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_err     <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_bits  <= '0;
      r_m_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_take && !w_is_term) begin
            r_state <= ACCUM;
            if (w_is_digit) begin
              r_acc <= w_next;
              r_err <= w_ovf;
            end else begin
              r_acc <= '0;
              r_err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (w_take) begin
            if (w_is_term) begin
              r_state   <= EMIT;
              r_m_valid <= 1'b1;
              r_m_err   <= r_err;
              r_m_bits  <= r_err ? '0 : r_acc[N_BITS-1:0];
            end else if (w_is_digit) begin
              r_acc <= w_next;
              if (w_ovf) r_err <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (m_ready) begin
            r_state   <= IDLE;
            r_m_valid <= 1'b0;
            r_acc     <= '0;
            r_err     <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m_valid = r_m_valid;
  assign m_bits  = r_m_bits;
  assign m_err   = r_m_err;

endmodule
